// File: rtl/sfp_ctrl.sv
// sfp_ctrl: sequencer for the SFP write-back pass over PSUM SRAM.
// Walks base_addr..base_addr+len-1 (mod 2^addr_bw), one RD then one WR per word,
// popping the OFIFO on each RD when the pass mode consumes OFIFO data.
// Optional feature macro: SFP_CTRL_RELU_EN enables mode 2'b10 as the ReLU pass;
// when undefined, mode 2'b10 is rejected like mode 2'b11.
module sfp_ctrl #(
   parameter int addr_bw = 4,
   parameter int len_bw  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [addr_bw-1:0] base_addr,
   input  logic [len_bw-1:0]  len,
   input  logic               ofifo_valid,
   output logic               ofifo_rd,
   output logic               sram_cen,
   output logic               sram_wen,
   output logic [addr_bw-1:0] sram_addr,
   output logic               accum,
   output logic               passthrough,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] MODE_ACC = 2'b00;
   localparam logic [1:0] MODE_PT  = 2'b01;

   state_t             state;
   state_t             state_next;
   logic [1:0]         mode_q;
   logic [addr_bw-1:0] base_q;
   logic [len_bw-1:0]  len_q;
   logic [len_bw-1:0]  idx;

   logic               mode_legal;
   logic               start_ok;
   logic               needs_ofifo;
   logic               stall;
   logic               last_word;
   logic [addr_bw-1:0] word_addr;

   // Decide whether a start request is acceptable and derive per-word conditions.
   always_comb begin
`ifdef SFP_CTRL_RELU_EN
      mode_legal = (mode != 2'b11);
`else
      mode_legal = (mode == MODE_ACC) || (mode == MODE_PT);
`endif
      start_ok    = start && (len != '0) && mode_legal;
      needs_ofifo = (mode_q == MODE_ACC) || (mode_q == MODE_PT);
      stall       = needs_ofifo && !ofifo_valid;
      last_word   = (idx == (len_q - len_bw'(1)));
      word_addr   = base_q + idx[addr_bw-1:0];
   end

   // State register plus the pass parameters captured when a start is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mode_q <= MODE_ACC;
         base_q <= '0;
         len_q  <= '0;
         idx    <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start_ok) begin
            mode_q <= mode;
            base_q <= base_addr;
            len_q  <= len;
            idx    <= '0;
         end else if (state == WR && !last_word) begin
            idx <= idx + len_bw'(1);
         end
      end
   end

   // Next-state and output decode; a stalled RD keeps the SRAM idle and skips the pop,
   // and passthrough never reads the SRAM because the SFP ignores the old contents.
   always_comb begin
      state_next  = state;
      ofifo_rd    = 1'b0;
      sram_cen    = 1'b1;
      sram_wen    = 1'b1;
      sram_addr   = '0;
      done        = 1'b0;
      busy        = (state != IDLE);
      accum       = busy && (mode_q == MODE_ACC);
      passthrough = busy && (mode_q == MODE_PT);
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_next = RD;
            end
         end
         RD: begin
            sram_addr = word_addr;
            if (!stall) begin
               ofifo_rd   = needs_ofifo;
               sram_cen   = (mode_q == MODE_PT);
               state_next = WR;
            end
         end
         WR: begin
            sram_addr  = word_addr;
            sram_cen   = 1'b0;
            sram_wen   = 1'b0;
            state_next = last_word ? DONE : RD;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sfp_ctrl.sv
// tb_sfp_ctrl: directed scenarios plus randomized traffic for sfp_ctrl, checked every
// cycle against a pass-level behavioural model kept in the bench.
module tb_sfp_ctrl;

   localparam int addr_bw = 4;
   localparam int len_bw  = 5;
`ifdef SFP_CTRL_RELU_EN
   localparam bit relu_en = 1'b1;
`else
   localparam bit relu_en = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [1:0]         mode = 2'b00;
   logic [addr_bw-1:0] base_addr = '0;
   logic [len_bw-1:0]  len = '0;
   logic               ofifo_valid = 1'b0;
   logic               ofifo_rd;
   logic               sram_cen;
   logic               sram_wen;
   logic [addr_bw-1:0] sram_addr;
   logic               accum;
   logic               passthrough;
   logic               busy;
   logic               done;

   sfp_ctrl #(.addr_bw(addr_bw), .len_bw(len_bw)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .len(len), .ofifo_valid(ofifo_valid),
      .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .accum(accum), .passthrough(passthrough),
      .busy(busy), .done(done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Pass-level model: whether a pass is running, which word, and whether that word is
   // in its write half; plus a flag for the single completion cycle.
   bit m_active = 1'b0;
   bit m_wr = 1'b0;
   bit m_done = 1'b0;
   int m_word = 0;
   int m_base = 0;
   int m_len = 0;
   int m_mode = 0;

   function automatic bit mode_ok(input int md);
      return (md == 0) || (md == 1) || (relu_en && md == 2);
   endfunction

   // Advance the model on each clock edge from the sampled inputs.
   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
         m_wr     = 1'b0;
         m_done   = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active) begin
         if (start && len != 0 && mode_ok(int'(mode))) begin
            m_active = 1'b1;
            m_wr     = 1'b0;
            m_word   = 0;
            m_base   = int'(base_addr);
            m_len    = int'(len);
            m_mode   = int'(mode);
         end
      end else if (!m_wr) begin
         if (!((m_mode == 0 || m_mode == 1) && !ofifo_valid)) m_wr = 1'b1;
      end else begin
         if (m_word == m_len - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end else begin
            m_word = m_word + 1;
            m_wr   = 1'b0;
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model once per cycle, away from the clock edge.
   always @(negedge clk) begin
      bit e_busy, e_rd, e_cen, e_wen;
      int e_addr;
      e_busy = m_active || m_done;
      e_addr = m_active ? ((m_base + m_word) % (1 << addr_bw)) : 0;
      e_rd   = m_active && !m_wr && (m_mode == 0 || m_mode == 1) && ofifo_valid;
      e_wen  = !(m_active && m_wr);
      if (m_active && m_wr)       e_cen = 1'b0;
      else if (!m_active)         e_cen = 1'b1;
      else if (m_mode == 1)       e_cen = 1'b1;
      else if (m_mode == 0)       e_cen = !ofifo_valid;
      else                        e_cen = 1'b0;
      check_output("busy", 32'(busy), 32'(e_busy));
      check_output("done", 32'(done), 32'(m_done));
      check_output("accum", 32'(accum), 32'(e_busy && m_mode == 0));
      check_output("passthrough", 32'(passthrough), 32'(e_busy && m_mode == 1));
      check_output("ofifo_rd", 32'(ofifo_rd), 32'(e_rd));
      check_output("sram_cen", 32'(sram_cen), 32'(e_cen));
      check_output("sram_wen", 32'(sram_wen), 32'(e_wen));
      check_output("sram_addr", 32'(sram_addr), 32'(e_addr));
   end

   // Event logs used by the directed scenarios.
   int wr_log[$];
   int pops = 0;
   int dones = 0;
   int reads = 0;
   always @(negedge clk) begin
      if (!reset) begin
         if (sram_cen === 1'b0 && sram_wen === 1'b0) wr_log.push_back(int'(sram_addr));
         if (sram_cen === 1'b0 && sram_wen === 1'b1) reads++;
         if (ofifo_rd === 1'b1) pops++;
         if (done === 1'b1) dones++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      pops  = 0;
      dones = 0;
      reads = 0;
   endtask

   task automatic apply_stimulus(input int md, input int b, input int l);
      mode      = 2'(md);
      base_addr = addr_bw'(b);
      len       = len_bw'(l);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      if (done !== 1'b1) check_output("done_timeout", 32'(done), 32'd1);
      step();
   endtask

   task automatic check_addrs(input string name, input int exp_q[$]);
      check_output({name, "_count"}, 32'(wr_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
         check_output(name, 32'(wr_log[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int lat;
      int exp_q[$];

      ofifo_valid = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      check_output("rst_cen", 32'(sram_cen), 32'd1);
      check_output("rst_wen", 32'(sram_wen), 32'd1);
      check_output("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      $display("[TB] accumulate pass");
      clear_logs();
      apply_stimulus(0, 3, 4);
      check_output("acc_accum", 32'(accum), 32'd1);
      wait_done(1, lat);
      check_output("acc_latency", 32'(lat), 32'd9);
      check_output("acc_busy_after", 32'(busy), 32'd0);
      check_output("acc_pops", 32'(pops), 32'd4);
      check_output("acc_dones", 32'(dones), 32'd1);
      exp_q = '{3, 4, 5, 6};
      check_addrs("acc_addr", exp_q);

      $display("[TB] ofifo stall");
      clear_logs();
      ofifo_valid = 1'b0;
      apply_stimulus(0, 7, 2);
      for (int i = 0; i < 3; i++) begin
         check_output("stall_cen", 32'(sram_cen), 32'd1);
         check_output("stall_pop", 32'(ofifo_rd), 32'd0);
         step();
      end
      ofifo_valid = 1'b1;
      wait_done(4, lat);
      check_output("stall_latency", 32'(lat), 32'd8);
      check_output("stall_pops", 32'(pops), 32'd2);
      exp_q = '{7, 8};
      check_addrs("stall_addr", exp_q);

      $display("[TB] wraparound passthrough");
      clear_logs();
      apply_stimulus(1, 14, 4);
      check_output("pt_passthrough", 32'(passthrough), 32'd1);
      check_output("pt_accum", 32'(accum), 32'd0);
      wait_done(1, lat);
      check_output("pt_latency", 32'(lat), 32'd9);
      check_output("pt_reads", 32'(reads), 32'd0);
      check_output("pt_pops", 32'(pops), 32'd4);
      exp_q = '{14, 15, 0, 1};
      check_addrs("pt_addr", exp_q);

      $display("[TB] ignored starts");
      apply_stimulus(0, 5, 0);
      check_output("len0_busy", 32'(busy), 32'd0);
      apply_stimulus(3, 5, 3);
      check_output("mode3_busy", 32'(busy), 32'd0);
      clear_logs();
      apply_stimulus(2, 5, 3);
      if (relu_en) begin
         wait_done(1, lat);
         check_output("relu_latency", 32'(lat), 32'd7);
         check_output("relu_pops", 32'(pops), 32'd0);
         check_output("relu_reads", 32'(reads), 32'd3);
         exp_q = '{5, 6, 7};
         check_addrs("relu_addr", exp_q);
      end else begin
         check_output("mode2_busy", 32'(busy), 32'd0);
      end

      clear_logs();
      apply_stimulus(0, 3, 4);
      step();
      step();
      mode = 2'b01; base_addr = 4'd10; len = 5'd2; start = 1'b1;
      step();
      start = 1'b0;
      check_output("mid_accum", 32'(accum), 32'd1);
      wait_done(4, lat);
      check_output("mid_latency", 32'(lat), 32'd9);
      exp_q = '{3, 4, 5, 6};
      check_addrs("mid_addr", exp_q);

      $display("[TB] reset mid-pass");
      clear_logs();
      apply_stimulus(0, 0, 5);
      step();
      step();
      step();
      check_output("pre_rst_wen", 32'(sram_wen), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_output("mrst_busy", 32'(busy), 32'd0);
      check_output("mrst_cen", 32'(sram_cen), 32'd1);
      check_output("mrst_wen", 32'(sram_wen), 32'd1);
      check_output("mrst_addr", 32'(sram_addr), 32'd0);
      check_output("mrst_accum", 32'(accum), 32'd0);
      repeat (12) step();
      check_output("mrst_dones", 32'(dones), 32'd0);
      clear_logs();
      apply_stimulus(0, 9, 5);
      wait_done(1, lat);
      check_output("post_rst_latency", 32'(lat), 32'd11);
      exp_q = '{9, 10, 11, 12, 13};
      check_addrs("post_rst_addr", exp_q);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         ofifo_valid = ($urandom_range(0, 3) != 0);
         start       = ($urandom_range(0, 4) == 0);
         mode        = 2'($urandom_range(0, 3));
         base_addr   = addr_bw'($urandom_range(0, 15));
         len         = len_bw'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6));
         reset       = ($urandom_range(0, 60) == 0);
         step();
      end
      start = 1'b0;
      reset = 1'b0;
      ofifo_valid = 1'b1;
      repeat (80) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
